mano_timing_ctrl: RTL and testbench
===================================

Name: mano_timing_ctrl

Overview:
Timing and instruction-decode stage of the basic computer. It drives the one-hot timing signals T[7:0] and the decoded opcode lines D[7:0] used by every register control block, including the DR load/clear/increment logic. The block contains the 3-bit sequence counter SC, the start/stop flip-flop S, the registered opcode decoder and the indirect bit I. It sits between the instruction register and the per-register control logic.

Parameters:
START_RUNNING, 1, reset value of S (1 = the machine runs out of reset).
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-high reset.
IR_OP  input  3  IR[14:12] opcode field.
IR_I  input  1  IR[15] addressing-mode bit.
SC_CLR  input  1  end-of-instruction request from the control logic; synchronous.
HLT  input  1  halt request; synchronous.
START  input  1  restart request; takes effect only when S=0.
T  output  8  one-hot timing signal; T[k]=1 when S=1 and SC=k; all zero when S=0.
D  output  8  registered one-hot opcode decode.
I  output  1  registered indirect bit.
S  output  1  run flip-flop.
SC  output  3  sequence counter value.
ERR  output  1  sticky flag: SC wrapped without a clear.
INSTR_CNT  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous): SC=0, D=8'h00, I=0, S=START_RUNNING, ERR=0, INSTR_CNT=0. T follows from S and SC, so T=8'h01 if START_RUNNING=1, otherwise 0.
- T is combinational from SC and S. Every other output is a flop.
- Edge priority while S=1, highest first:
  1. HLT=1: S←0, SC←0, D←0, I←0. INSTR_CNT is unchanged.
  2. SC_CLR=1: SC←0, D←0, I unchanged, INSTR_CNT←INSTR_CNT+1 (wraps modulo 2^CNT_W).
  3. SC==2: D←onehot(IR_OP), I←IR_I, SC←3.
  4. SC==7: SC←0, ERR←1, D←0.
  5. Otherwise: SC←SC+1.
- Latency: D and I become valid starting in T3. They read 0 (I keeps its old value) during T0–T2 of the next instruction. D is never multi-hot.
- SC_CLR asserted during T2 takes priority: D is not loaded. SC_CLR during T0 or T1 is legal and restarts at T0.
- While S=0: SC, D and I hold at 0 and T=0. SC_CLR and HLT are ignored.
  - START=1 sets S←1 on the next edge; the first cycle after that edge is T0.
- START while S=1 has no effect. When HLT and START are both high, HLT wins.
- ERR stays set until RST.
- Reset asserted mid-instruction forces the reset values immediately, without waiting for a clock edge. Operation resumes from T0 on the first edge after release if START_RUNNING=1.

Test Plan:
- Reset release, START_RUNNING=1, SC_CLR asserted at SC=5 → T sequence 01,02,04,08,10,20,01. After the SC_CLR edge D=00 and INSTR_CNT=1.
- Start from a cleared D. IR_OP=3'b010, IR_I=1 held through T2 → from T3 onward D=8'h04 and I=1. D=00 again after SC_CLR.
- Apply no SC_CLR for 8 cycles → SC goes 7 then 0, ERR=1 and stays 1 after later SC_CLRs. Only RST clears it.
- HLT pulsed at T4 → next cycle S=0, T=00, D=00. START pulsed 3 cycles later → T=01 on the cycle after.
- HLT and START high together while S=1 → S=0. SC_CLR and HLT together → S=0 and INSTR_CNT unchanged.
- RST asserted asynchronously between edges during T5 → T=01 and D=00 immediately. Stepping INSTR_CNT from 16'hFFFF with one more SC_CLR → 0.

Source files
------------

// File: rtl/mano_timing_ctrl_if.sv
// ============================================================================
// mano_timing_ctrl_if
// Bundles the opcode/control inputs and timing/decode outputs of the
// timing-control stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mano_timing_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       IR_OP;
  logic             IR_I;
  logic             SC_CLR;
  logic             HLT;
  logic             START;
  logic [7:0]       T;
  logic [7:0]       D;
  logic             I;
  logic             S;
  logic [2:0]       SC;
  logic             ERR;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output IR_OP, IR_I, SC_CLR, HLT, START,
    input  T, D, I, S, SC, ERR, INSTR_CNT
  );

  modport slave (
    input  IR_OP, IR_I, SC_CLR, HLT, START,
    output T, D, I, S, SC, ERR, INSTR_CNT
  );
endinterface

`default_nettype wire

// File: rtl/mano_timing_ctrl.sv
// ============================================================================
// mano_timing_ctrl
// Sequence counter, run flip-flop, registered opcode decode and indirect bit
// producing the T/D timing lines of the basic computer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mano_timing_ctrl #(
  parameter bit START_RUNNING = 1'b1,
  parameter int CNT_W         = 16
) (
  input  wire                   CLK,
  input  wire                   RST,
  mano_timing_ctrl_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_t;

  localparam run_t       C_RUN_RST = START_RUNNING ? ST_RUN : ST_STOP;
  localparam [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  run_t             run_q, run_d;
  logic [2:0]       sc_q, sc_d;
  logic [7:0]       dec_q, dec_d;
  logic             ind_q, ind_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q <= C_RUN_RST;
      sc_q  <= 3'd0;
      dec_q <= 8'h00;
      ind_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      dec_q <= dec_d;
      ind_q <= ind_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    dec_d = dec_q;
    ind_d = ind_q;
    err_d = err_q;
    cnt_d = cnt_q;

    case (run_q)
      ST_RUN: begin
        if (bus.HLT) begin
          run_d = ST_STOP;
          sc_d  = 3'd0;
          dec_d = 8'h00;
          ind_d = 1'b0;
        end else if (bus.SC_CLR) begin
          // Retire the instruction; I keeps its value until the next T2 load.
          sc_d  = 3'd0;
          dec_d = 8'h00;
          cnt_d = cnt_q + C_CNT_ONE;
        end else if (sc_q == 3'd2) begin
          dec_d = 8'd1 << bus.IR_OP;
          ind_d = bus.IR_I;
          sc_d  = 3'd3;
        end else if (sc_q == 3'd7) begin
          // Counter ran off the end of T7 without a clear: flag it sticky.
          sc_d  = 3'd0;
          err_d = 1'b1;
          dec_d = 8'h00;
        end else begin
          sc_d = sc_q + 3'd1;
        end
      end
      default: begin
        sc_d  = 3'd0;
        dec_d = 8'h00;
        ind_d = 1'b0;
        if (bus.START) begin
          run_d = ST_RUN;
        end
      end
    endcase
  end

  assign bus.T         = (run_q == ST_RUN) ? (8'd1 << sc_q) : 8'h00;
  assign bus.D         = dec_q;
  assign bus.I         = ind_q;
  assign bus.S         = run_q;
  assign bus.SC        = sc_q;
  assign bus.ERR       = err_q;
  assign bus.INSTR_CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mano_timing_ctrl.sv
// ============================================================================
// tb_mano_timing_ctrl
// Scoreboard bench: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mano_timing_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    logic [7:0]       t;
    logic [7:0]       d;
    logic             i;
    logic             s;
    logic [2:0]       sc;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic CLK;
  logic RST;
  mano_timing_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mano_timing_ctrl #(.START_RUNNING(1'b1), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  // Reference model state, expressed at instruction/phase level
  bit running;
  int phase;
  int dec_op;   // -1 when no opcode is decoded
  bit ind;
  bit err;
  int retired;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  function automatic exp_t expect_now();
    exp_t e;
    e.t   = running ? 8'(2 ** phase) : 8'h00;
    e.d   = (dec_op < 0) ? 8'h00 : 8'(2 ** dec_op);
    e.i   = ind;
    e.s   = running;
    e.sc  = 3'(phase);
    e.err = err;
    e.cnt = CNT_W'(retired);
    return e;
  endfunction

  task automatic model_reset();
    running = 1'b1;
    phase   = 0;
    dec_op  = -1;
    ind     = 1'b0;
    err     = 1'b0;
    retired = 0;
  endtask

  task automatic model_edge();
    if (RST) begin
      model_reset();
    end else if (running) begin
      if (bus.HLT) begin
        running = 1'b0;
        phase   = 0;
        dec_op  = -1;
        ind     = 1'b0;
      end else if (bus.SC_CLR) begin
        phase   = 0;
        dec_op  = -1;
        retired = (retired + 1) % (1 << CNT_W);
      end else if (phase == 2) begin
        dec_op = int'(bus.IR_OP);
        ind    = bus.IR_I;
        phase  = 3;
      end else if (phase == 7) begin
        phase  = 0;
        err    = 1'b1;
        dec_op = -1;
      end else begin
        phase = phase + 1;
      end
    end else if (bus.START) begin
      running = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("T",         32'(bus.T),         32'(e.t));
      chk("D",         32'(bus.D),         32'(e.d));
      chk("I",         32'(bus.I),         32'(e.i));
      chk("S",         32'(bus.S),         32'(e.s));
      chk("SC",        32'(bus.SC),        32'(e.sc));
      chk("ERR",       32'(bus.ERR),       32'(e.err));
      chk("INSTR_CNT", 32'(bus.INSTR_CNT), 32'(e.cnt));
    end
  end

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    exp_q.push_back(expect_now());
  endtask

  // Reset lands between edges; the pending expectation is replaced by reset values
  task automatic async_reset();
    #1;
    RST = 1'b1;
    model_reset();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(expect_now());
  endtask

  task automatic set_in(input logic clr, input logic hlt, input logic start,
                        input logic [2:0] op, input logic ind_bit);
    bus.SC_CLR = clr;
    bus.HLT    = hlt;
    bus.START  = start;
    bus.IR_OP  = op;
    bus.IR_I   = ind_bit;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    RST = 1'b1;
    model_reset();
    #1;
    exp_q.push_back(expect_now());
    cycle();
    RST = 1'b0;

    // Opcode 010 with I=1, then retire at T5
    set_in(1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    repeat (5) cycle();
    set_in(1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 3'b101, 1'b0);

    // Run off the end of T7, then more clears leave ERR set
    repeat (9) cycle();
    set_in(1'b1, 1'b0, 1'b0, 3'b101, 1'b0);
    repeat (2) cycle();

    // Halt at T4, restart three cycles later
    set_in(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
    repeat (4) cycle();
    set_in(1'b0, 1'b1, 1'b0, 3'b111, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
    repeat (3) cycle();
    set_in(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
    repeat (2) cycle();

    // HLT+START together while running, then SC_CLR+HLT together
    set_in(1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    cycle();

    // Asynchronous reset during T5
    set_in(1'b0, 1'b0, 1'b0, 3'b110, 1'b1);
    repeat (5) cycle();
    async_reset();
    cycle();
    RST = 1'b0;
    repeat (3) cycle();

    // Randomised traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 149) == 0) async_reset();
      set_in(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 29) == 0),
             1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
    end

    // Retired-instruction counter wraps from FFFF to 0
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    async_reset();
    cycle();
    RST = 1'b0;
    repeat (65536) cycle();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (2) cycle();

    @(negedge CLK);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
